ingame_round_fsm: RTL and testbench
===================================

// Module: ingame_round_fsm
// PURPOSE
//  In-game round controller for the tile-matching game: the consumer of the mode FSM's ingameOn and the producer of its gameOver.
//  Accepts tile selections, reads tile values, compares pairs, tracks matched/revealed tiles and counts, and raises gameOver when all pairs are matched.
//  Sits between the mode FSM, the board value ROM and the VGA/HEX display logic.
// PARAMETERS
//  N_TILES       16          tiles on board; must be even; N_TILES/2 pairs
//  IDX_W         4           tile index width, clog2(N_TILES)
//  VAL_W         3           tile value (pair id) width
//  HOLD_CYCLES   25_000_000  mismatch reveal time in clocks (0.5 s @ 50 MHz); must be >= 1
//  TICKS_PER_SEC 50_000_000  timer prescale (ROUND_TIMER_EN only)
//  TIME_LIMIT_S  60          round length in seconds, <=127 (ROUND_TIMER_EN only)
// PORTS
//  CLOCK_50      in   1        system clock
//  resetn        in   1        asynchronous active-low reset
//  ingameOn      in   1        level from mode FSM; round runs while high
//  sel_valid     in   1        one-cycle pulse: player selected tile sel_idx
//  sel_idx       in   IDX_W    selected tile index
//  tile_rd_idx   out  IDX_W    registered ROM read address
//  tile_rd_val   in   VAL_W    ROM data for tile_rd_idx (async ROM, sampled 1 cycle after address update)
//  sel_reject    out  1        one-cycle pulse: selection ignored
//  revealed_mask out  N_TILES  tiles currently face-up (unmatched selections)
//  matched_mask  out  N_TILES  tiles permanently matched
//  match_count   out  IDX_W    pairs matched so far
//  move_count    out  8        pair comparisons made, saturates at 255
//  time_left     out  7        seconds remaining (0 when ROUND_TIMER_EN is undefined)
//  gameOver      out  1        level; high in DONE until ingameOn falls
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE.
//  States: IDLE, WAIT_FIRST, READ_FIRST, WAIT_SECOND, READ_SECOND, COMPARE, HOLD, DONE.
//  IDLE: clear masks, counts and hold counter; load timer. Go to WAIT_FIRST when ingameOn=1.
//  WAIT_FIRST: when sel_valid and sel_idx is not matched and sel_idx<N_TILES:
//   latch idx A; set tile_rd_idx=A; set revealed bit A; go to READ_FIRST. Otherwise pulse sel_reject.
//  READ_FIRST: latch value A from tile_rd_val; go to WAIT_SECOND.
//  WAIT_SECOND: same acceptance rule, plus sel_idx!=A; latch B; set revealed bit B; tile_rd_idx=B; go to READ_SECOND.
//  READ_SECOND: latch value B; go to COMPARE.
//  COMPARE: move_count++ (saturating).
//   On equal values: set matched bits A and B, clear revealed bits A and B, match_count++.
//   If the new match_count equals N_TILES/2, go to DONE; otherwise go to WAIT_FIRST.
//   On unequal values: go to HOLD.
//  HOLD: count HOLD_CYCLES clocks; sel_valid is rejected (sel_reject pulse); then clear revealed bits A and B and go to WAIT_FIRST.
//  DONE: gameOver=1; all selections rejected; masks and counts frozen for display.
//  Any state: ingameOn=0 returns to IDLE on the next edge; gameOver drops in that same edge. This holds mid-compare and mid-hold.
//  sel_valid in READ_*/COMPARE states: rejected (pulse), not queued.
//  Selection-to-COMPARE latency: 2 cycles after the second accepted selection.
//  Reset mid-round: immediate async return to reset values.
// CONFIGURATION
//  ROUND_TIMER_EN defined:
//   time_left loads TIME_LIMIT_S in IDLE and decrements every TICKS_PER_SEC clocks in WAIT_*/READ_*/COMPARE/HOLD.
//   On reaching 0, go to DONE (gameOver=1) regardless of state; a match completing in the same cycle still goes to DONE with counts updated.
//  ROUND_TIMER_EN undefined: no timer logic; time_left tied to 0; DONE is entered only via all pairs matched.
// STRUCTURE
//  Shared package tile_game_pkg: state encodings, N_TILES/IDX_W/VAL_W defaults, HOLD_CYCLES, TICKS_PER_SEC.
//  One sub-module: round_timer (prescaler plus seconds down-counter, load/enable/expired), instantiated only under ROUND_TIMER_EN.
// TESTING (bench: HOLD_CYCLES=4, TICKS_PER_SEC=10, TIME_LIMIT_S=3; ROM pairs tile i with tile i^1)
//  1 Reset, ingameOn=1, select 0 then 1 -> 2 cycles later matched_mask=0x0003, match_count=1, move_count=1, revealed_mask=0.
//  2 Select 2 then 5 -> revealed_mask=0x0024 for 4 hold cycles, then 0; a sel_valid during HOLD -> sel_reject pulse, state unchanged.
//  3 Select 0 (already matched) -> sel_reject; select 3 twice -> second rejected; revealed_mask=0x0008.
//  4 Match all 8 pairs -> gameOver=1 and held; drop ingameOn -> gameOver=0 next edge, masks cleared.
//  5 Drop ingameOn during HOLD; assert resetn=0 mid-READ_SECOND -> IDLE and all outputs 0.
//  6 (ROUND_TIMER_EN) Idle with ingameOn=1 for 30 clocks -> time_left 3,2,1,0; gameOver=1 at expiry.

Source files
------------

// File: rtl/tile_game_pkg.sv
// Shared definitions for the tile-matching game: round FSM state encoding,
// board/timing defaults and a counter-width helper.
package tile_game_pkg;

  localparam int N_TILES_DEF       = 16;
  localparam int IDX_W_DEF         = 4;
  localparam int VAL_W_DEF         = 3;
  localparam int HOLD_CYCLES_DEF   = 25_000_000;
  localparam int TICKS_PER_SEC_DEF = 50_000_000;
  localparam int TIME_LIMIT_S_DEF  = 60;

  localparam int MOVE_W = 8;
  localparam int TIME_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FIRST,
    ST_READ_FIRST,
    ST_WAIT_SECOND,
    ST_READ_SECOND,
    ST_COMPARE,
    ST_HOLD,
    ST_DONE
  } round_state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ingame_round_fsm_if.sv
// Signal bundle between the round FSM (slave) and the mode FSM / board ROM /
// display side (master).
interface ingame_round_fsm_if
  import tile_game_pkg::*;
#(
  parameter int N_TILES = N_TILES_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int VAL_W   = VAL_W_DEF
) ();

  logic                 ingameOn;
  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     tile_rd_idx;
  logic [VAL_W-1:0]     tile_rd_val;
  logic                 sel_reject;
  logic [N_TILES-1:0]   revealed_mask;
  logic [N_TILES-1:0]   matched_mask;
  logic [IDX_W-1:0]     match_count;
  logic [MOVE_W-1:0]    move_count;
  logic [TIME_W-1:0]    time_left;
  logic                 gameOver;

  modport master (
    output ingameOn, sel_valid, sel_idx, tile_rd_val,
    input  tile_rd_idx, sel_reject, revealed_mask, matched_mask,
           match_count, move_count, time_left, gameOver
  );

  modport slave (
    input  ingameOn, sel_valid, sel_idx, tile_rd_val,
    output tile_rd_idx, sel_reject, revealed_mask, matched_mask,
           match_count, move_count, time_left, gameOver
  );

endinterface

// File: rtl/round_timer.sv
// Round countdown: a clock prescaler feeding a seconds down-counter.
// Only instantiated when ROUND_TIMER_EN is defined.
module round_timer
  import tile_game_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int TIME_LIMIT_S  = TIME_LIMIT_S_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              en_i,
  output logic [TIME_W-1:0] time_o,
  output logic              expire_o
);

  localparam int PRE_W = cnt_width(TICKS_PER_SEC - 1);

  logic [PRE_W-1:0]  pre_q;
  logic [TIME_W-1:0] sec_q;
  logic              tick;

  assign tick = en_i && (pre_q == PRE_W'(TICKS_PER_SEC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      sec_q <= '0;
    end else if (load_i) begin
      pre_q <= '0;
      sec_q <= TIME_W'(TIME_LIMIT_S);
    end else if (en_i) begin
      if (tick) begin
        pre_q <= '0;
        if (sec_q != '0) sec_q <= sec_q - 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  // Fires on the edge that takes the count to zero, so the round ends together with it.
  assign expire_o = en_i && ((sec_q == '0) || (tick && sec_q == TIME_W'(1)));
  assign time_o   = sec_q;

endmodule

// File: rtl/ingame_round_fsm.sv
// In-game round controller: takes tile selections, compares pairs, tracks
// revealed/matched tiles and raises gameOver. Optional timer: ROUND_TIMER_EN.
module ingame_round_fsm
  import tile_game_pkg::*;
#(
  parameter int N_TILES       = N_TILES_DEF,
  parameter int IDX_W         = IDX_W_DEF,
  parameter int VAL_W         = VAL_W_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int TIME_LIMIT_S  = TIME_LIMIT_S_DEF
) (
  input logic               CLOCK_50,
  input logic               resetn,
  ingame_round_fsm_if.slave bus
);

  localparam int PAIRS  = N_TILES / 2;
  localparam int HOLD_W = cnt_width(HOLD_CYCLES - 1);

  if ((N_TILES % 2) != 0 || HOLD_CYCLES < 1 || TICKS_PER_SEC < 1 ||
      TIME_LIMIT_S > 127 || (1 << IDX_W) < N_TILES) begin : g_bad_cfg
    $error("ingame_round_fsm: illegal parameter combination");
  end

  round_state_e state_q, state_d;

  logic [IDX_W-1:0]   idx_a_q, idx_b_q, rd_idx_q;
  logic [VAL_W-1:0]   val_a_q, val_b_q;
  logic [N_TILES-1:0] revealed_q, matched_q;
  logic [IDX_W-1:0]   match_cnt_q;
  logic [MOVE_W-1:0]  move_cnt_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic               reject_q;

  logic sel_free, accept_first, accept_second, vals_equal, last_pair, hold_done;
  logic timer_expire, clear_all;
  logic take_first, take_second, latch_a, latch_b, do_compare;
  logic hold_step, hold_clear, reject, game_over;

  assign sel_free      = (32'(bus.sel_idx) < 32'(N_TILES)) && !matched_q[bus.sel_idx];
  assign accept_first  = bus.sel_valid && sel_free;
  assign accept_second = bus.sel_valid && sel_free && (bus.sel_idx != idx_a_q);
  assign vals_equal    = (val_a_q == val_b_q);
  assign last_pair     = (32'(match_cnt_q) + 32'd1) == 32'(PAIRS);
  assign hold_done     = (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1));
  // Leaving the round (or sitting idle) wipes the board state on the same edge.
  assign clear_all     = !bus.ingameOn || (state_q == ST_IDLE);

`ifdef ROUND_TIMER_EN
  logic timer_en;
  assign timer_en = state_q inside {ST_WAIT_FIRST, ST_READ_FIRST, ST_WAIT_SECOND,
                                    ST_READ_SECOND, ST_COMPARE, ST_HOLD};

  round_timer #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .TIME_LIMIT_S  (TIME_LIMIT_S)
  ) u_round_timer (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .load_i   (clear_all),
    .en_i     (timer_en),
    .time_o   (bus.time_left),
    .expire_o (timer_expire)
  );
`else
  assign bus.time_left = '0;
  assign timer_expire  = 1'b0;
`endif

  // NOTE: clocked blocks use non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (bus.ingameOn) state_d = ST_WAIT_FIRST;
      ST_WAIT_FIRST:  if (accept_first) state_d = ST_READ_FIRST;
      ST_READ_FIRST:  state_d = ST_WAIT_SECOND;
      ST_WAIT_SECOND: if (accept_second) state_d = ST_READ_SECOND;
      ST_READ_SECOND: state_d = ST_COMPARE;
      ST_COMPARE: begin
        if (!vals_equal)    state_d = ST_HOLD;
        else if (last_pair) state_d = ST_DONE;
        else                state_d = ST_WAIT_FIRST;
      end
      ST_HOLD:        if (hold_done) state_d = ST_WAIT_FIRST;
      ST_DONE:        state_d = ST_DONE;
      default:        state_d = ST_IDLE;
    endcase
    if (timer_expire)   state_d = ST_DONE;
    if (!bus.ingameOn)  state_d = ST_IDLE;
  end

  always_comb begin
    take_first  = 1'b0;
    take_second = 1'b0;
    latch_a     = 1'b0;
    latch_b     = 1'b0;
    do_compare  = 1'b0;
    hold_step   = 1'b0;
    hold_clear  = 1'b0;
    reject      = 1'b0;
    game_over   = 1'b0;
    case (state_q)
      ST_WAIT_FIRST: begin
        take_first = accept_first;
        reject     = bus.sel_valid && !accept_first;
      end
      ST_READ_FIRST: begin
        latch_a = 1'b1;
        reject  = bus.sel_valid;
      end
      ST_WAIT_SECOND: begin
        take_second = accept_second;
        reject      = bus.sel_valid && !accept_second;
      end
      ST_READ_SECOND: begin
        latch_b = 1'b1;
        reject  = bus.sel_valid;
      end
      ST_COMPARE: begin
        do_compare = 1'b1;
        reject     = bus.sel_valid;
      end
      ST_HOLD: begin
        hold_step  = !hold_done;
        hold_clear = hold_done;
        reject     = bus.sel_valid;
      end
      ST_DONE: begin
        game_over = 1'b1;
        reject    = bus.sel_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      idx_a_q     <= '0;
      idx_b_q     <= '0;
      rd_idx_q    <= '0;
      val_a_q     <= '0;
      val_b_q     <= '0;
      revealed_q  <= '0;
      matched_q   <= '0;
      match_cnt_q <= '0;
      move_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      reject_q    <= 1'b0;
    end else if (clear_all) begin
      idx_a_q     <= '0;
      idx_b_q     <= '0;
      rd_idx_q    <= '0;
      val_a_q     <= '0;
      val_b_q     <= '0;
      revealed_q  <= '0;
      matched_q   <= '0;
      match_cnt_q <= '0;
      move_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      reject_q    <= 1'b0;
    end else begin
      reject_q   <= reject;
      hold_cnt_q <= hold_step ? hold_cnt_q + 1'b1 : '0;
      if (take_first) begin
        idx_a_q              <= bus.sel_idx;
        rd_idx_q             <= bus.sel_idx;
        revealed_q[bus.sel_idx] <= 1'b1;
      end
      if (take_second) begin
        idx_b_q              <= bus.sel_idx;
        rd_idx_q             <= bus.sel_idx;
        revealed_q[bus.sel_idx] <= 1'b1;
      end
      if (latch_a) val_a_q <= bus.tile_rd_val;
      if (latch_b) val_b_q <= bus.tile_rd_val;
      if (do_compare) begin
        if (move_cnt_q != '1) move_cnt_q <= move_cnt_q + 1'b1;
        if (vals_equal) begin
          matched_q[idx_a_q]  <= 1'b1;
          matched_q[idx_b_q]  <= 1'b1;
          revealed_q[idx_a_q] <= 1'b0;
          revealed_q[idx_b_q] <= 1'b0;
          match_cnt_q         <= match_cnt_q + 1'b1;
        end
      end
      if (hold_clear) begin
        revealed_q[idx_a_q] <= 1'b0;
        revealed_q[idx_b_q] <= 1'b0;
      end
    end
  end

  assign bus.tile_rd_idx   = rd_idx_q;
  assign bus.sel_reject    = reject_q;
  assign bus.revealed_mask = revealed_q;
  assign bus.matched_mask  = matched_q;
  assign bus.match_count   = match_cnt_q;
  assign bus.move_count    = move_cnt_q;
  assign bus.gameOver      = game_over;

endmodule

// File: tb/tb_ingame_round_fsm.sv
// Self-checking bench for ingame_round_fsm: directed scenarios plus a randomized
// full game against a board-level model (tile i pairs with tile i^1).
module tb_ingame_round_fsm;

  localparam int N    = 16;
  localparam int IW   = 4;
  localparam int VW   = 3;
  localparam int HOLD = 4;
  localparam int TPS  = 10;
  localparam int TLIM = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ingame_round_fsm_if #(.N_TILES(N), .IDX_W(IW), .VAL_W(VW)) bus ();

  ingame_round_fsm #(
    .N_TILES(N), .IDX_W(IW), .VAL_W(VW),
    .HOLD_CYCLES(HOLD), .TICKS_PER_SEC(TPS), .TIME_LIMIT_S(TLIM)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (rst_n),
    .bus      (bus)
  );

  // Board ROM: both tiles of a pair share a scrambled pair id.
  function automatic logic [VW-1:0] rom_val(input int idx);
    return VW'((idx >> 1) ^ 5);
  endfunction

  assign bus.tile_rd_val = rom_val(int'(bus.tile_rd_idx));

  int tests = 0;
  int fails = 0;

  bit [N-1:0] m_matched, m_revealed;
  int         m_pairs, m_moves;
  bit         m_over;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_revealed"}, 32'(bus.revealed_mask), 32'(m_revealed));
    check({tag, "_matched"},  32'(bus.matched_mask),  32'(m_matched));
    check({tag, "_pairs"},    32'(bus.match_count),   32'(m_pairs));
    check({tag, "_moves"},    32'(bus.move_count),    32'(m_moves));
    check({tag, "_gameover"}, 32'(bus.gameOver),      32'(m_over));
  endtask

  task automatic model_clear();
    m_matched  = '0;
    m_revealed = '0;
    m_pairs    = 0;
    m_moves    = 0;
    m_over     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input int idx);
    bus.sel_valid = 1'b1;
    bus.sel_idx   = IW'(idx);
    tick();
    bus.sel_valid = 1'b0;
  endtask

  // One cycle where the DUT is busy: either idle, or poke a selection that must bounce.
  task automatic busy_cycle(input string tag, input bit force_poke);
    if (force_poke || $urandom_range(0, 1) == 1) begin
      select($urandom_range(0, N - 1));
      check({tag, "_busy_reject"}, 32'(bus.sel_reject), 32'd1);
    end else begin
      tick();
    end
  endtask

  function automatic int pick_free(input int excl);
    int c;
    do c = $urandom_range(0, N - 1); while (m_matched[c] || c == excl);
    return c;
  endfunction

  // Full pair attempt from WAIT_FIRST, with the model deciding match/mismatch.
  task automatic play_pair(input string tag, input int a, input int b, input bit force_poke);
    select(a);
    m_revealed[a] = 1'b1;
    check({tag, "_acc_a"}, 32'(bus.sel_reject), 32'd0);
    check({tag, "_rd_a"},  32'(bus.tile_rd_idx), 32'(a));
    busy_cycle(tag, 1'b0);
    select(b);
    m_revealed[b] = 1'b1;
    check({tag, "_acc_b"}, 32'(bus.sel_reject), 32'd0);
    check({tag, "_rd_b"},  32'(bus.tile_rd_idx), 32'(b));
    check({tag, "_rev_ab"}, 32'(bus.revealed_mask), 32'(m_revealed));
    busy_cycle(tag, 1'b0);
    tick();
    m_moves = (m_moves < 255) ? m_moves + 1 : 255;
    if (rom_val(a) == rom_val(b)) begin
      m_matched[a]  = 1'b1;
      m_matched[b]  = 1'b1;
      m_revealed[a] = 1'b0;
      m_revealed[b] = 1'b0;
      m_pairs++;
      m_over = (m_pairs == N / 2);
      check_all({tag, "_match"});
    end else begin
      check_all({tag, "_hold0"});
      for (int i = 1; i < HOLD; i++) begin
        busy_cycle(tag, force_poke && i == 1);
        check({tag, "_hold_rev"}, 32'(bus.revealed_mask), 32'(m_revealed));
      end
      tick();
      m_revealed[a] = 1'b0;
      m_revealed[b] = 1'b0;
      check_all({tag, "_unhold"});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int guard;
    int a, b;
    bus.ingameOn  = 1'b0;
    bus.sel_valid = 1'b0;
    bus.sel_idx   = '0;
    rst_n         = 1'b0;
    model_clear();
    tick();
    tick();

    // Reset state.
    check_all("reset");
    check("reset_reject", 32'(bus.sel_reject), 32'd0);
    check("reset_rdidx",  32'(bus.tile_rd_idx), 32'd0);
    check("reset_time",   32'(bus.time_left), 32'd0);
    rst_n = 1'b1;
    tick();

`ifndef ROUND_TIMER_EN
    // 1: first pair matches.
    bus.ingameOn = 1'b1;
    tick();
    play_pair("t1", 0, 1, 1'b0);
    check("t1_matched", 32'(bus.matched_mask), 32'h0003);

    // 2: mismatch, reveal held, selection during hold bounces.
    play_pair("t2", 2, 5, 1'b1);

    // 3: matched tile and duplicate selection rejected.
    select(0);
    check("t3_matched_rej", 32'(bus.sel_reject), 32'd1);
    check("t3_rev_none",    32'(bus.revealed_mask), 32'h0000);
    select(3);
    check("t3_acc3",  32'(bus.sel_reject), 32'd0);
    check("t3_rev3",  32'(bus.revealed_mask), 32'h0008);
    tick();
    select(3);
    check("t3_dup_rej", 32'(bus.sel_reject), 32'd1);
    check("t3_dup_rev", 32'(bus.revealed_mask), 32'h0008);
    select(2);
    check("t3_acc2", 32'(bus.sel_reject), 32'd0);
    tick();
    tick();
    m_matched[3:0] = 4'hf;
    m_pairs++;
    m_moves++;
    check_all("t3_pair");

    // 4: randomized rest of the game.
    guard = 0;
    while (m_pairs < N / 2 && guard < 200) begin
      a = pick_free(-1);
      b = ($urandom_range(0, 1) == 1) ? (a ^ 1) : pick_free(a);
      play_pair("t4", a, b, 1'b0);
      guard++;
    end
    check("t4_all_pairs", 32'(bus.match_count), 32'(N / 2));
    check("t4_gameover",  32'(bus.gameOver), 32'd1);
    select($urandom_range(0, N - 1));
    check("t4_done_rej", 32'(bus.sel_reject), 32'd1);
    tick();
    check_all("t4_frozen");
    bus.ingameOn = 1'b0;
    tick();
    model_clear();
    check_all("t4_exit");
    check("t4_exit_rdidx", 32'(bus.tile_rd_idx), 32'd0);

    // 5: leave mid-hold, then async reset mid-READ_SECOND.
    bus.ingameOn = 1'b1;
    tick();
    select(4);
    tick();
    select(7);
    tick();
    tick();
    check("t5_hold_rev", 32'(bus.revealed_mask), 32'h0090);
    tick();
    bus.ingameOn = 1'b0;
    tick();
    check_all("t5_hold_exit");
    bus.ingameOn = 1'b1;
    tick();
    select(6);
    tick();
    select(9);
    check("t5_rev_pre", 32'(bus.revealed_mask), 32'h0240);
    #1;
    rst_n = 1'b0;
    #1;
    check_all("t5_async_rst");
    check("t5_rst_rdidx",  32'(bus.tile_rd_idx), 32'd0);
    check("t5_rst_reject", 32'(bus.sel_reject), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
`else
    // 6: timer runs out with no selections.
    bus.ingameOn = 1'b1;
    tick();
    check("t6_load", 32'(bus.time_left), 32'(TLIM));
    for (int k = 1; k <= TLIM * TPS + 2; k++) begin
      tick();
      check("t6_time", 32'(bus.time_left),
            32'((k >= TLIM * TPS) ? 0 : TLIM - k / TPS));
      check("t6_gameover", 32'(bus.gameOver), 32'(k >= TLIM * TPS));
    end
    bus.ingameOn = 1'b0;
    tick();
    check("t6_exit_gameover", 32'(bus.gameOver), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
